// File: rtl/pa_soc_rbm_hs.sv
// Register bus matrix: routes one master to SLV_NUM slaves by an address bit field, waiting for slave ready.
// Optional feature macro RBM_TIMEOUT_EN: bounds ACCESS to TIMEOUT cycles and answers a stalled slave with an error.
module pa_soc_rbm_hs #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SLV_NUM = 8,
   parameter int unsigned SEL_HI  = 31,
   parameter int unsigned SEL_LO  = 28,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [ADDR_W-1:0]         m_addr_i,
   input  logic                      m_we_i,
   input  logic                      m_rd_i,
   output logic [DATA_W-1:0]         m_data_o,
   output logic                      m_ready_o,
   output logic                      m_err_o,
   output logic [SLV_NUM-1:0]        s_we_o,
   output logic [SLV_NUM-1:0]        s_rd_o,
   input  logic [SLV_NUM*DATA_W-1:0] s_data_i,
   input  logic [SLV_NUM-1:0]        s_ready_i
);

   localparam int unsigned SEL_W = SEL_HI - SEL_LO + 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state;
   logic [SEL_W-1:0]   idx;
   logic [SEL_W-1:0]   sel_q;
   logic               wr_q;
   logic               req;
   logic               conflict;
   logic               unmapped;
   logic [SLV_NUM-1:0] sel_hot;
   logic               sel_ready;
   logic [DATA_W-1:0]  rdata;
   logic               unused_ok;

`ifdef RBM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0]   cnt;
`endif

   assign idx      = m_addr_i[SEL_HI:SEL_LO];
   assign req      = m_we_i | m_rd_i;
   assign conflict = m_we_i & m_rd_i;
   assign unmapped = 32'(idx) >= 32'(SLV_NUM);
   assign sel_hot  = SLV_NUM'(1) << idx;

   // Address bits outside the select field are decoded by the slaves themselves.
   assign unused_ok = (^m_addr_i) ^ (TIMEOUT == 0);

   // Ready and read data of the latched slave.
   always_comb begin
      sel_ready = 1'b0;
      rdata     = '0;
      for (int k = 0; k < SLV_NUM; k++) begin
         if (sel_q == SEL_W'(k)) begin
            sel_ready = s_ready_i[k];
            rdata     = s_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         sel_q     <= '0;
         wr_q      <= 1'b0;
         m_data_o  <= '0;
         m_ready_o <= 1'b0;
         m_err_o   <= 1'b0;
         s_we_o    <= '0;
         s_rd_o    <= '0;
`ifdef RBM_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (conflict || unmapped) begin
                     state     <= RESP;
                     m_ready_o <= 1'b1;
                     m_err_o   <= 1'b1;
                     m_data_o  <= '0;
                  end else begin
                     state  <= ACCESS;
                     sel_q  <= idx;
                     wr_q   <= m_we_i;
                     s_we_o <= m_we_i ? sel_hot : '0;
                     s_rd_o <= m_we_i ? '0 : sel_hot;
`ifdef RBM_TIMEOUT_EN
                     cnt    <= '0;
`endif
                  end
               end
            end
            ACCESS: begin
               // Ready in the final allowed cycle still completes without error.
               if (sel_ready) begin
                  state     <= RESP;
                  m_ready_o <= 1'b1;
                  m_err_o   <= 1'b0;
                  s_we_o    <= '0;
                  s_rd_o    <= '0;
                  if (!wr_q) begin
                     m_data_o <= rdata;
                  end
               end
`ifdef RBM_TIMEOUT_EN
               else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state     <= RESP;
                  m_ready_o <= 1'b1;
                  m_err_o   <= 1'b1;
                  m_data_o  <= '0;
                  s_we_o    <= '0;
                  s_rd_o    <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end
            RESP: begin
               state     <= IDLE;
               m_ready_o <= 1'b0;
               m_err_o   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pa_soc_rbm_hs.sv
// Bench for pa_soc_rbm_hs: per-cycle expectation tables built from transaction rules, compared every cycle.
module tb_pa_soc_rbm_hs;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned NS   = 8;
   localparam int unsigned TO   = 16;
   localparam int          MAXC = 2048;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [AW-1:0]     m_addr_i;
   logic              m_we_i;
   logic              m_rd_i;
   logic [DW-1:0]     m_data_o;
   logic              m_ready_o;
   logic              m_err_o;
   logic [NS-1:0]     s_we_o;
   logic [NS-1:0]     s_rd_o;
   logic [NS*DW-1:0]  s_data_i;
   logic [NS-1:0]     s_ready_i;

   pa_soc_rbm_hs #(
      .ADDR_W(AW), .DATA_W(DW), .SLV_NUM(NS), .SEL_HI(31), .SEL_LO(28), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_rd_i(m_rd_i),
      .m_data_o(m_data_o), .m_ready_o(m_ready_o), .m_err_o(m_err_o),
      .s_we_o(s_we_o), .s_rd_o(s_rd_o), .s_data_i(s_data_i), .s_ready_i(s_ready_i)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // Expected outputs per absolute cycle
   bit [NS-1:0] e_we   [MAXC];
   bit [NS-1:0] e_rd   [MAXC];
   bit          e_rdy  [MAXC];
   bit          e_err  [MAXC];
   bit          e_upd  [MAXC];
   bit          e_rst  [MAXC];
   bit [DW-1:0] e_dval [MAXC];

   logic [DW-1:0] sdata [NS];
   logic [DW-1:0] model_data = '0;
   bit            chk_en = 1'b0;

   int            stb_cnt;
   logic [NS-1:0] stb_or;
   int            rdy_cyc;
   logic          err_seen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk_i) begin : compare
      int c;
      c = cyc;
      if (chk_en && c < MAXC) begin
         if (e_rst[c]) model_data = '0;
         else if (e_rdy[c] && e_upd[c]) model_data = e_dval[c];
         check("s_we_o", 64'(s_we_o), 64'(e_we[c]));
         check("s_rd_o", 64'(s_rd_o), 64'(e_rd[c]));
         check("m_ready_o", 64'(m_ready_o), 64'(e_rdy[c]));
         check("m_err_o", 64'(m_err_o), 64'(e_err[c]));
         check("m_data_o", 64'(m_data_o), 64'(model_data));
         if (s_we_o != '0 || s_rd_o != '0) begin
            stb_cnt++;
            stb_or = stb_or | s_we_o | s_rd_o;
         end
         if (m_ready_o) begin
            rdy_cyc  = c;
            err_seen = m_err_o;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int k);
      m_we_i    = 1'b0;
      m_rd_i    = 1'b0;
      s_ready_i = '0;
      repeat (k) next_cycle();
   endtask

   // Issue one access; n = wait cycles after strobe before slave ready (negative = never).
   task automatic txn(input logic [31:0] addr, input bit we, input bit rd, input int n,
                      input logic [NS-1:0] noise);
      int c0, idx, len, rc;
      bit err, bad;
      c0  = cyc;
      idx = int'(addr[31:28]);
      bad = (we && rd) || (idx >= int'(NS));
      stb_cnt = 0;
      stb_or  = '0;
      rdy_cyc = -1;
      if (bad) begin
         rc = c0 + 1;
         e_rdy[rc] = 1'b1; e_err[rc] = 1'b1; e_upd[rc] = 1'b1; e_dval[rc] = '0;
      end else begin
         err = 1'b0;
         len = n + 1;
`ifdef RBM_TIMEOUT_EN
         if (n < 0 || n >= int'(TO)) begin
            len = int'(TO);
            err = 1'b1;
         end
`endif
         for (int c = c0 + 1; c <= c0 + len; c++) begin
            e_we[c] = we ? (NS'(1) << idx) : '0;
            e_rd[c] = we ? '0 : (NS'(1) << idx);
         end
         rc = c0 + 1 + len;
         e_rdy[rc]  = 1'b1;
         e_err[rc]  = err;
         e_upd[rc]  = err || rd;
         e_dval[rc] = err ? '0 : sdata[idx];
      end
      m_addr_i = addr;
      m_we_i   = we;
      m_rd_i   = rd;
      for (int c = c0; c <= rc; c++) begin
         if (c != c0) next_cycle();
         s_ready_i = noise & ~(NS'(1) << idx);
         if (!bad && n >= 0 && c == c0 + 1 + n) s_ready_i = s_ready_i | (NS'(1) << idx);
      end
      next_cycle();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin : stim
      int t0, c0;
      for (int k = 0; k < int'(NS); k++) begin
         sdata[k] = (k == 1) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(k));
         s_data_i[k*DW +: DW] = sdata[k];
      end

      // Reset with random inputs
      rst_i = 1'b1;
      m_addr_i = $urandom; m_we_i = 1'($urandom); m_rd_i = 1'($urandom); s_ready_i = NS'($urandom);
      e_rst[1] = 1'b1;
      e_rst[2] = 1'b1;
      next_cycle();
      chk_en = 1'b1;
      check("reset_outputs", {m_ready_o, m_err_o, s_we_o, s_rd_o, m_data_o}, 64'h0);
      m_addr_i = $urandom; m_we_i = 1'($urandom); m_rd_i = 1'($urandom); s_ready_i = NS'($urandom);
      next_cycle();
      rst_i = 1'b0;
      idle(2);

      // Read slave 1, ready immediately
      t0 = cyc;
      txn(32'h1000_0004, 1'b0, 1'b1, 0, '0);
      check("rd_data", 64'(m_data_o), 64'hDEAD_BEEF);
      check("rd_strobe", 64'(stb_or), 64'h02);
      check("rd_stb_cycles", 64'(stb_cnt), 64'd1);
      check("rd_latency", 64'(rdy_cyc - t0), 64'd2);
      check("rd_err", 64'(err_seen), 64'd0);
      idle(1);

      // Write slave 3 after 3 waits, others ready all along; then back-to-back read
      t0 = cyc;
      txn(32'h3000_0000, 1'b1, 1'b0, 3, 8'hFF);
      check("wr_stb_cycles", 64'(stb_cnt), 64'd4);
      check("wr_strobe", 64'(stb_or), 64'h08);
      check("wr_latency", 64'(rdy_cyc - t0), 64'd5);
      check("wr_data_kept", 64'(m_data_o), 64'hDEAD_BEEF);
      t0 = cyc;
      txn(32'h2000_0000, 1'b0, 1'b1, 1, '0);
      check("b2b_strobe", 64'(stb_or), 64'h04);
      check("b2b_latency", 64'(rdy_cyc - t0), 64'd3);
      check("b2b_data", 64'(m_data_o), 64'hA5A5_0002);
      idle(1);

      // Unmapped, then conflicting request
      t0 = cyc;
      txn(32'h9000_0000, 1'b0, 1'b1, 0, 8'hFF);
      check("unmap_latency", 64'(rdy_cyc - t0), 64'd1);
      check("unmap_err", 64'(err_seen), 64'd1);
      check("unmap_stb", 64'(stb_cnt), 64'd0);
      check("unmap_data", 64'(m_data_o), 64'h0);
      t0 = cyc;
      txn(32'h0000_0000, 1'b1, 1'b1, 0, '0);
      check("conf_latency", 64'(rdy_cyc - t0), 64'd1);
      check("conf_err", 64'(err_seen), 64'd1);
      check("conf_stb", 64'(stb_cnt), 64'd0);
      idle(2);

      // Highest slave, low address bits set, noisy neighbours
      t0 = cyc;
      txn(32'h7FFF_FFFC, 1'b0, 1'b1, 2, 8'h7F);
      check("s7_latency", 64'(rdy_cyc - t0), 64'd4);
      check("s7_data", 64'(m_data_o), 64'hA5A5_0007);
      idle(1);

`ifdef RBM_TIMEOUT_EN
      // Slave 4 never ready
      t0 = cyc;
      txn(32'h4000_0000, 1'b0, 1'b1, -1, '0);
      check("to_stb_cycles", 64'(stb_cnt), 64'd16);
      check("to_strobe", 64'(stb_or), 64'h10);
      check("to_latency", 64'(rdy_cyc - t0), 64'd17);
      check("to_err", 64'(err_seen), 64'd1);
      check("to_data", 64'(m_data_o), 64'h0);
      idle(1);
`endif
      // Slave 4 ready in the 16th strobe cycle
      t0 = cyc;
      txn(32'h4000_0000, 1'b0, 1'b1, 15, '0);
      check("last_stb_cycles", 64'(stb_cnt), 64'd16);
      check("last_latency", 64'(rdy_cyc - t0), 64'd17);
      check("last_err", 64'(err_seen), 64'd0);
      check("last_data", 64'(m_data_o), 64'hA5A5_0004);
      idle(1);

      // Reset during the 2nd ACCESS cycle of a read
      c0 = cyc;
      stb_cnt = 0;
      stb_or  = '0;
      rdy_cyc = -1;
      e_rd[c0+1] = NS'(8'h04);
      e_rd[c0+2] = NS'(8'h04);
      e_rst[c0+3] = 1'b1;
      m_addr_i = 32'h2000_0000; m_rd_i = 1'b1; m_we_i = 1'b0; s_ready_i = '0;
      next_cycle();
      next_cycle();
      rst_i = 1'b1;
      next_cycle();
      rst_i = 1'b0;
      idle(4);
      check("rst_no_ready", 64'(rdy_cyc), 64'(-1));
      check("rst_stb_cycles", 64'(stb_cnt), 64'd2);
      check("rst_data", 64'(m_data_o), 64'h0);

      t0 = cyc;
      txn(32'h0000_0010, 1'b0, 1'b1, 0, '0);
      check("post_rst_latency", 64'(rdy_cyc - t0), 64'd2);
      check("post_rst_data", 64'(m_data_o), 64'hA5A5_0000);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
